// File: rtl/noc_pkg.sv
// Shared NoC definitions: port count, port-code width, port codes and the
// per-output allocator state type. Routing and buffer blocks import this too.
package noc_pkg;

  localparam int NOC_NUM_PORTS = 5;
  localparam int NOC_PORT_W    = 3;

  localparam logic [NOC_PORT_W-1:0] PORT_R  = 3'd0;
  localparam logic [NOC_PORT_W-1:0] PORT_L  = 3'd1;
  localparam logic [NOC_PORT_W-1:0] PORT_U  = 3'd2;
  localparam logic [NOC_PORT_W-1:0] PORT_D  = 3'd3;
  localparam logic [NOC_PORT_W-1:0] PORT_EJ = 3'd4;

  typedef enum logic {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } sa_state_e;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers, the crossbar and the
// switch allocator. The master side is the router datapath, the slave side
// is the allocator.
interface switch_allocator_if
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int PORT_W    = NOC_PORT_W
);

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS*PORT_W-1:0] req_dest;
  logic [NUM_PORTS-1:0]        req_tail;
  logic [NUM_PORTS-1:0]        out_ready;
  logic [NUM_PORTS-1:0]        grant;
  logic [NUM_PORTS-1:0]        out_valid;
  logic [NUM_PORTS*PORT_W-1:0] out_sel;

  modport master (
    output req_valid, req_dest, req_tail, out_ready,
    input  grant, out_valid, out_sel
  );

  modport slave (
    input  req_valid, req_dest, req_tail, out_ready,
    output grant, out_valid, out_sel
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// the pointer, wrapping cyclically over NUM_PORTS entries.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int PORT_W    = NOC_PORT_W
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PORT_W-1:0]    i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic                 o_valid
);

  // Scan from the pointer onwards and keep only the first hit.
  always_comb begin
    int idx;
    o_gnt   = '0;
    o_valid = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(i_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!o_valid && (i == idx) && i_req[i]) begin
          o_gnt[i] = 1'b1;
          o_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator. Each output locks onto one input for
// a whole packet and releases on the tail flit; arbitration is round-robin
// and costs one cycle before the first flit moves.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   SA_IDLE   | no owner; pick a requester this cycle, lock at the next edge
//   SA_LOCKED | owner fixed; flits move whenever owner requests and out ready
module switch_allocator
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NOC_NUM_PORTS,
  parameter int PORT_W    = NOC_PORT_W
) (
  input  logic             clk,
  input  logic             reset,
  switch_allocator_if.slave bus
);

  sa_state_e             r_state  [NUM_PORTS];
  logic [PORT_W-1:0]     r_owner  [NUM_PORTS];
  logic [PORT_W-1:0]     r_rr_ptr [NUM_PORTS];

  logic [PORT_W-1:0]     w_dest     [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_cand     [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_win      [NUM_PORTS];
  logic [PORT_W-1:0]     w_win_code [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_win_vld;
  logic [NUM_PORTS-1:0]  w_xfer;
  logic [NUM_PORTS-1:0]  w_grant;
  logic [NUM_PORTS*PORT_W-1:0] w_sel;

  // Unpack destination codes and build per-output candidate vectors.
  // Codes >= NUM_PORTS never match an output index, so they never request.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dest[i] = bus.req_dest[i*PORT_W +: PORT_W];
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_cand[o][i] = bus.req_valid[i] && (w_dest[i] == PORT_W'(o));
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
    ) u_rr_arbiter (
      .i_req   (w_cand[g]),
      .i_ptr   (r_rr_ptr[g]),
      .o_gnt   (w_win[g]),
      .o_valid (w_win_vld[g])
    );
  end

  // One-hot winner to port code.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_win_code[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_win[o][i]) w_win_code[o] = PORT_W'(i);
      end
    end
  end

  // A locked output moves a flit only while its owner still points at it;
  // a wandering req_dest simply stalls the output.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_xfer[o] = (r_state[o] == SA_LOCKED) &&
                  bus.req_valid[r_owner[o]] &&
                  (w_dest[r_owner[o]] == PORT_W'(o)) &&
                  bus.out_ready[o];
    end
  end

  // Fold transfers back onto inputs and drive the crossbar selects.
  always_comb begin
    w_grant = '0;
    w_sel   = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (r_state[o] == SA_LOCKED) w_sel[o*PORT_W +: PORT_W] = r_owner[o];
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_xfer[o] && (r_owner[o] == PORT_W'(i))) w_grant[i] = 1'b1;
      end
    end
  end

  assign bus.grant     = w_grant;
  assign bus.out_valid = w_xfer;
  assign bus.out_sel   = w_sel;

  // Per-output lock FSM with round-robin pointer update on tail release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_state[o]  <= SA_IDLE;
        r_owner[o]  <= '0;
        r_rr_ptr[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        case (r_state[o])
          SA_IDLE: begin
            if (w_win_vld[o]) begin
              r_owner[o] <= w_win_code[o];
              r_state[o] <= SA_LOCKED;
            end
          end
          SA_LOCKED: begin
            if (w_xfer[o] && bus.req_tail[r_owner[o]]) begin
              r_state[o]  <= SA_IDLE;
              r_rr_ptr[o] <= (r_owner[o] == PORT_W'(NUM_PORTS-1)) ?
                             '0 : r_owner[o] + PORT_W'(1);
            end
          end
          default: r_state[o] <= SA_IDLE;
        endcase
      end
    end
  end

endmodule
